fp_issue: RTL and testbench

Request sequencer between the integer pipeline and the floating-point execution unit. Accepts FP operations over a valid/ready handshake into a small in-order FIFO, issues one operation at a time to the execution unit (single-cycle `enable` pulse, wait for `ready`), and returns result, flags and tag over a valid/ready response port. Accumulates sticky exception flags (fflags) for the CSR file.

---
 rtl/fp_issue_if.sv | 58 +++++
 rtl/fp_issue.sv | 172 +++++++++++++++++
 tb/tb_fp_issue.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_issue_if.sv
// Handshake bundle between the integer pipeline, the FP sequencer and the FP execution unit.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface fp_issue_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_data1;
  logic [31:0]      req_data2;
  logic [31:0]      req_data3;
  logic [18:0]      req_op;
  logic [1:0]       req_fmt;
  logic [2:0]       req_rm;
  logic [TAG_W-1:0] req_tag;

  logic [31:0]      exe_data1;
  logic [31:0]      exe_data2;
  logic [31:0]      exe_data3;
  logic [18:0]      exe_op;
  logic [1:0]       exe_fmt;
  logic [2:0]       exe_rm;
  logic             exe_enable;
  logic [31:0]      exe_result;
  logic [4:0]       exe_flags;
  logic             exe_ready;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [4:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;

  logic             busy;
  logic [4:0]       fflags_acc;
  logic             fflags_clr;

  modport slave (
    input  req_valid, req_data1, req_data2, req_data3, req_op, req_fmt, req_rm, req_tag,
    output req_ready,
    output exe_data1, exe_data2, exe_data3, exe_op, exe_fmt, exe_rm, exe_enable,
    input  exe_result, exe_flags, exe_ready,
    output rsp_valid, rsp_result, rsp_flags, rsp_tag,
    input  rsp_ready,
    output busy, fflags_acc,
    input  fflags_clr
  );

  modport master (
    output req_valid, req_data1, req_data2, req_data3, req_op, req_fmt, req_rm, req_tag,
    input  req_ready,
    input  exe_data1, exe_data2, exe_data3, exe_op, exe_fmt, exe_rm, exe_enable,
    output exe_result, exe_flags, exe_ready,
    input  rsp_valid, rsp_result, rsp_flags, rsp_tag,
    output rsp_ready,
    input  busy, fflags_acc,
    output fflags_clr
  );
endinterface

// File: rtl/fp_issue.sv
// In-order FP request sequencer: request FIFO, single-issue FSM towards the execution unit,
// registered response port and sticky exception-flag accumulator.
module fp_issue #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic        clock,
  input  logic        reset,
  fp_issue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]      d1;
    logic [31:0]      d2;
    logic [31:0]      d3;
    logic [18:0]      op;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_rsp_result;
  logic [4:0]       r_rsp_flags;
  logic [TAG_W-1:0] r_rsp_tag;
  logic [4:0]       r_fflags_acc;

  entry_t           w_head;
  entry_t           w_req_entry;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_capture;
  logic             w_enable;
  logic             w_rsp_hs;

  // Full-FIFO refusal depends only on the registered count, so no path from the pop side.
  assign bus.req_ready = (r_count < CNT_W'(DEPTH));
  assign w_empty       = (r_count == {CNT_W{1'b0}});
  assign w_push        = bus.req_valid && bus.req_ready;
  assign w_pop         = w_capture;
  assign w_rsp_hs      = (r_state == S_RESP) && bus.rsp_ready;
  assign w_head        = r_mem[r_rd_ptr];

  assign w_req_entry = '{d1: bus.req_data1, d2: bus.req_data2, d3: bus.req_data3,
                         op: bus.req_op, fmt: bus.req_fmt, rm: bus.req_rm, tag: bus.req_tag};

  // FIFO storage and pointers; storage is cleared so idle exe_* outputs are never X.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_req_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and issue decode; exe_ready outside an active issue is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_enable    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_enable = 1'b1;
          if (bus.exe_ready) begin
            w_capture   = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.exe_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Response register and sticky flags; a clear coinciding with a handshake keeps that response's flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rsp_result <= 32'd0;
      r_rsp_flags  <= 5'd0;
      r_rsp_tag    <= {TAG_W{1'b0}};
      r_fflags_acc <= 5'd0;
    end else begin
      if (w_capture) begin
        r_rsp_result <= bus.exe_result;
        r_rsp_flags  <= bus.exe_flags;
        r_rsp_tag    <= w_head.tag;
      end
      if (bus.fflags_clr) begin
        r_fflags_acc <= w_rsp_hs ? r_rsp_flags : 5'd0;
      end else if (w_rsp_hs) begin
        r_fflags_acc <= r_fflags_acc | r_rsp_flags;
      end else begin
        r_fflags_acc <= r_fflags_acc;
      end
    end
  end

  assign bus.exe_data1  = w_head.d1;
  assign bus.exe_data2  = w_head.d2;
  assign bus.exe_data3  = w_head.d3;
  assign bus.exe_op     = w_head.op;
  assign bus.exe_fmt    = w_head.fmt;
  assign bus.exe_rm     = w_head.rm;
  assign bus.exe_enable = w_enable;

  assign bus.rsp_valid  = (r_state == S_RESP);
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_flags  = r_rsp_flags;
  assign bus.rsp_tag    = r_rsp_tag;
  assign bus.busy       = (!w_empty) || (r_state != S_IDLE);
  assign bus.fflags_acc = r_fflags_acc;
endmodule

// File: tb/tb_fp_issue.sv
// Directed bench for fp_issue: a stub execution unit checks issued operands, and a
// scoreboard monitor checks every response handshake against queued expectations.
module tb_fp_issue;
  localparam logic [18:0] OP_FADD = 19'h00004;
  localparam logic [18:0] OP_FDIV = 19'h00020;
  localparam logic [18:0] OP_FMUL = 19'h00010;

  typedef struct {
    logic [119:0] ops;
    int           lat;
    logic [31:0]  res;
    logic [4:0]   fl;
  } iss_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    logic [4:0]  tag;
  } rsp_t;

  logic clock;
  logic reset;
  logic stray;
  int   n_vec;
  int   n_err;
  int   hs_count;
  iss_t stub_q[$];
  rsp_t sb_q[$];

  fp_issue_if #(.TAG_W(5)) bus ();

  fp_issue #(.DEPTH(2), .TAG_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [119:0] exe_pack();
    return {bus.exe_data1, bus.exe_data2, bus.exe_data3, bus.exe_op, bus.exe_fmt, bus.exe_rm};
  endfunction

  // Stub execution unit: answers each enable after the queued latency.
  initial begin
    iss_t cur;
    int   wait_cnt;
    bit   active;
    active         = 1'b0;
    wait_cnt       = 0;
    bus.exe_ready  = 1'b0;
    bus.exe_result = 32'd0;
    bus.exe_flags  = 5'd0;
    forever begin
      @(negedge clock);
      bus.exe_ready  = 1'b0;
      bus.exe_result = 32'd0;
      bus.exe_flags  = 5'd0;
      if (reset) begin
        active = 1'b0;
      end else if (stray) begin
        bus.exe_ready  = 1'b1;
        bus.exe_result = 32'hDEADBEEF;
        bus.exe_flags  = 5'h1F;
      end else if (active) begin
        chk("exe_hold", exe_pack(), cur.ops);
        chk("busy_wait", bus.busy, 1'b1);
        chk("no_reissue", bus.exe_enable, 1'b0);
        wait_cnt--;
        if (wait_cnt == 0) begin
          bus.exe_ready  = 1'b1;
          bus.exe_result = cur.res;
          bus.exe_flags  = cur.fl;
          active         = 1'b0;
        end
      end else if (bus.exe_enable) begin
        if (stub_q.size() == 0) begin
          chk("enable_unexpected", 1'b1, 1'b0);
        end else begin
          cur = stub_q.pop_front();
          chk("exe_issue", exe_pack(), cur.ops);
          if (cur.lat == 0) begin
            bus.exe_ready  = 1'b1;
            bus.exe_result = cur.res;
            bus.exe_flags  = cur.fl;
          end else begin
            active   = 1'b1;
            wait_cnt = cur.lat;
          end
        end
      end
    end
  end

  // Scoreboard monitor: every response handshake must match the oldest expectation.
  initial begin
    rsp_t e;
    hs_count = 0;
    forever begin
      @(negedge clock);
      if (!reset && bus.rsp_valid && bus.rsp_ready) begin
        hs_count++;
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp", {bus.rsp_result, bus.rsp_flags, bus.rsp_tag}, {e.res, e.fl, e.tag});
        end
      end
    end
  end

  task automatic send(input logic [18:0] op, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [4:0] tag, input int lat, input logic [31:0] res,
                      input logic [4:0] fl);
    iss_t s;
    rsp_t r;
    int   guard;
    bus.req_valid = 1'b1;
    bus.req_data1 = d1;
    bus.req_data2 = d2;
    bus.req_data3 = d1 ^ d2;
    bus.req_op    = op;
    bus.req_fmt   = tag[1:0];
    bus.req_rm    = tag[2:0];
    bus.req_tag   = tag;
    s.ops = {d1, d2, d1 ^ d2, op, tag[1:0], tag[2:0]};
    s.lat = lat;
    s.res = res;
    s.fl  = fl;
    r.res = res;
    r.fl  = fl;
    r.tag = tag;
    stub_q.push_back(s);
    sb_q.push_back(r);
    guard = 0;
    @(negedge clock);
    while (!bus.req_ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) chk("req_accept_timeout", 1'b0, 1'b1);
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clock);
    while ((sb_q.size() != 0 || bus.busy) && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 300) chk("drain_timeout", 1'b0, 1'b1);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rsp();
    int guard;
    guard = 0;
    @(negedge clock);
    while (!bus.rsp_valid && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) chk("rsp_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int hs0;
    n_vec          = 0;
    n_err          = 0;
    reset          = 1'b1;
    stray          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_data1  = 32'd0;
    bus.req_data2  = 32'd0;
    bus.req_data3  = 32'd0;
    bus.req_op     = 19'd0;
    bus.req_fmt    = 2'd0;
    bus.req_rm     = 3'd0;
    bus.req_tag    = 5'd0;
    bus.rsp_ready  = 1'b1;
    bus.fflags_clr = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    @(negedge clock);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_outputs", {bus.rsp_valid, bus.exe_enable, bus.busy}, 3'b000);
    chk("rst_rsp", {bus.rsp_result, bus.rsp_flags, bus.rsp_tag, bus.fflags_acc}, 47'd0);
    chk("rst_exe", exe_pack(), 120'd0);
    @(posedge clock);
    #1;

    // Single op, zero latency: enable one cycle after accept, response the cycle after.
    send(OP_FADD, 32'h3F800000, 32'h40000000, 5'd7, 0, 32'h40400000, 5'h00);
    @(negedge clock);
    chk("lat0_enable", {bus.exe_enable, bus.rsp_valid}, 2'b10);
    @(negedge clock);
    chk("lat0_rsp_valid", {bus.exe_enable, bus.rsp_valid}, 2'b01);
    wait_idle();

    // Long op with flags.
    send(OP_FDIV, 32'h3F800000, 32'h40400000, 5'd3, 10, 32'h3EAAAAAB, 5'h01);
    wait_idle();
    chk("acc_after_div", bus.fflags_acc, 5'h01);

    // FIFO full: third request waits for the first pop.
    send(OP_FMUL, 32'h11111111, 32'h22222222, 5'd1, 5, 32'hA0000001, 5'h00);
    send(OP_FMUL, 32'h33333333, 32'h44444444, 5'd2, 5, 32'hA0000002, 5'h00);
    @(negedge clock);
    chk("full_req_ready", bus.req_ready, 1'b0);
    @(posedge clock);
    #1;
    send(OP_FMUL, 32'h55555555, 32'h66666666, 5'd3, 5, 32'hA0000003, 5'h00);
    wait_idle();

    // Response backpressure: response held, nothing new issued, one handshake on release.
    bus.rsp_ready = 1'b0;
    send(OP_FADD, 32'h01020304, 32'h05060708, 5'd9, 0, 32'hCAFEF00D, 5'h02);
    send(OP_FADD, 32'h0A0B0C0D, 32'h0E0F1011, 5'd10, 0, 32'h12345678, 5'h00);
    wait_rsp();
    for (int i = 0; i < 8; i++) begin
      chk("bp_hold", {bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_tag, bus.exe_enable},
          {1'b1, 32'hCAFEF00D, 5'h02, 5'd9, 1'b0});
      @(negedge clock);
    end
    hs0 = hs_count;
    @(posedge clock);
    #1;
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clock);
    chk("bp_one_hs", hs_count - hs0, 1);
    chk("bp_bubble", bus.rsp_valid, 1'b0);
    @(posedge clock);
    #1;
    bus.rsp_ready = 1'b1;
    wait_idle();
    chk("acc_after_bp", bus.fflags_acc, 5'h03);

    // Flag clear alone, accumulate 0x04, then clear colliding with a 0x01 handshake.
    bus.fflags_clr = 1'b1;
    @(posedge clock);
    #1;
    bus.fflags_clr = 1'b0;
    @(negedge clock);
    chk("acc_clear", bus.fflags_acc, 5'h00);
    @(posedge clock);
    #1;
    send(OP_FDIV, 32'h00000000, 32'h00000000, 5'd4, 2, 32'h7FC00000, 5'h04);
    wait_idle();
    chk("acc_04", bus.fflags_acc, 5'h04);
    bus.rsp_ready = 1'b0;
    send(OP_FADD, 32'h3F800001, 32'h3F800001, 5'd5, 1, 32'h40000001, 5'h01);
    wait_rsp();
    @(posedge clock);
    #1;
    bus.fflags_clr = 1'b1;
    bus.rsp_ready  = 1'b1;
    @(posedge clock);
    #1;
    bus.fflags_clr = 1'b0;
    @(negedge clock);
    chk("acc_clr_collision", bus.fflags_acc, 5'h01);
    wait_idle();

    // Reset while one op waits and another is queued, then a stray completion.
    send(OP_FMUL, 32'h77777777, 32'h88888888, 5'd11, 20, 32'h0BADF00D, 5'h10);
    send(OP_FMUL, 32'h99999999, 32'hAAAAAAAA, 5'd12, 20, 32'h0BADF00E, 5'h10);
    @(negedge clock);
    chk("pre_reset_busy", bus.busy, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    sb_q.delete();
    stub_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    stray = 1'b1;
    @(posedge clock);
    #1;
    stray = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("post_reset_ctl", {bus.rsp_valid, bus.busy, bus.exe_enable, bus.req_ready}, 4'b0001);
      chk("post_reset_data", {bus.rsp_result, bus.rsp_flags, bus.rsp_tag, bus.fflags_acc}, 47'd0);
      chk("post_reset_exe", exe_pack(), 120'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
